ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single 16-bit system RAM port between two requesters.
  - m0: the CPU control unit.
  - m1: the video/DMA fetch engine.
- Sits between the requesters and the RAM block.
  - Serialises accesses.
  - Drives the RAM read/write enables for exactly one cycle per access.
  - Returns read data and a one-cycle acknowledge to the requester that won arbitration.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- READ_LATENCY, 1, cycles from the ram_read_en cycle to the cycle in which ram_rdata is valid. Legal range 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- m0_req  in  1  CPU request; held until m0_ack
- m0_we  in  1  1 = write, 0 = read
- m0_addr  in  ADDR_W  CPU address
- m0_wdata  in  DATA_W  CPU write data
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  DATA_W  CPU read data; valid when m0_ack is high, held afterwards
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as m0, for video/DMA
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_read_en  out  1  RAM read strobe
- ram_write_en  out  1  RAM write strobe
- ram_rdata  in  DATA_W  RAM read data
- busy  out  1  high in every state except IDLE
- owner  out  1  port of the current or most recent grant (0 = m0, 1 = m1)

Behaviour:
- Reset values:
  - State = IDLE.
  - All outputs 0, including m0_rdata, m1_rdata, ram_addr, ram_wdata and owner.
  - Latency counter 0.
- All outputs are registered.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - With no request, stay in IDLE.
  - Any req high: choose the winner, latch its addr/wdata/we into internal registers, set owner, go to ACCESS.
  - Both requests high: m0 wins (fixed priority), unless the optional feature is enabled.
- ACCESS, exactly one cycle:
  - ram_addr and ram_wdata show the latched values.
  - ram_write_en = latched we; ram_read_en = !latched we.
  - Write: go to DONE.
  - Read: load the counter with READ_LATENCY-1 and go to WAIT.
- WAIT:
  - Both enables are 0.
  - Counter at 0: capture ram_rdata into the owner's mX_rdata and go to DONE.
  - Otherwise decrement the counter and stay in WAIT.
- DONE, one cycle:
  - The owner's mX_ack = 1 (read data is already on mX_rdata in this cycle).
  - The req inputs are ignored in this cycle.
  - Go to IDLE.
- Timing, with the request first sampled in IDLE at cycle T:
  - Write: write_en in T+1, ack in T+2.
  - Read: read_en in T+1, rdata sampled in T+1+READ_LATENCY, ack in T+2+READ_LATENCY.
  - Back-to-back throughput: one write per 3 cycles.
- Requester rules:
  - The requester holds req, we, addr and wdata stable until it samples ack high.
  - It may deassert req, or present a new request, from the cycle after ack.
  - Input changes after the IDLE latch have no effect on the access in flight.
- ram_addr and ram_wdata hold their last values while idle. ram_read_en and ram_write_en are never high together and never high outside ACCESS.
- mX_rdata changes only on completion of a read for that port. Writes and the other port's reads leave it unchanged.
- A request that arrives while busy waits, with no loss, until the next IDLE cycle.
- Reset mid-transaction:
  - The access is aborted and no ack is issued.
  - Enables are 0 from the cycle after rst is sampled.

Optional Feature:
- Macro: RAM_ARB_ROUND_ROBIN_EN.
- Defined:
  - A simultaneous m0/m1 request in IDLE is granted to the port that is not owner, so grants alternate under contention.
  - owner resets to 1, so the first tie goes to m0.
  - A single requester is always granted immediately.
- Undefined:
  - Fixed priority; m0 always wins ties.
  - m1 can starve under continuous m0 traffic.

Test Plan:
- m0 write, addr=0x0100, data=0xBEEF, READ_LATENCY=1:
  - ram_write_en high for one cycle with ram_addr=0x0100 and ram_wdata=0xBEEF.
  - m0_ack high exactly 2 cycles after req is sampled.
  - m0_rdata unchanged.
- m0 read of 0x0100 with RAM model returning 0xBEEF:
  - ram_read_en high for one cycle.
  - m0_ack 3 cycles after the request, with m0_rdata=0xBEEF.
  - m1_ack stays 0.
- READ_LATENCY=3, m1 read of 0x2000 returning 0x1234:
  - m1_ack 5 cycles after the request, with m1_rdata=0x1234.
  - busy high throughout.
- m0 and m1 requesting continuously in the same cycle:
  - Without the macro: m0 is granted every time and m1_ack never pulses within 10 grants.
  - With RAM_ARB_ROUND_ROBIN_EN: grants alternate m0, m1, m0, m1.
- rst asserted in WAIT during an m1 read:
  - No m1_ack.
  - All outputs 0 on the next cycle.
  - A following m0 write completes normally.
- m0 changes m0_addr to 0x0FFF during the ACCESS cycle of a write to 0x0100:
  - RAM sees 0x0100.
  - No second access is issued during DONE even though m0_req is still high.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port arbiter for the shared 16-bit system RAM: m0 = CPU, m1 = video/DMA fetch.
// Define RAM_ARB_ROUND_ROBIN_EN to alternate grants under contention (default: m0 has fixed priority).
module ram_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_read_en,
    output logic              ram_write_en,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    localparam int CNT_W = 2;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    localparam logic OWNER_RST = 1'b1;
`else
    localparam logic OWNER_RST = 1'b0;
`endif

    state_t             state;
    logic [CNT_W-1:0]   lat_cnt;
    logic               lat_we;
    logic               grant_m1;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    // Winner selection in IDLE; ties go to m0 unless round-robin hands them to the non-owner.
    always_comb begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
        grant_m1 = m1_req && (!m0_req || !owner);
`else
        grant_m1 = m1_req && !m0_req;
`endif
        sel_we    = grant_m1 ? m1_we    : m0_we;
        sel_addr  = grant_m1 ? m1_addr  : m0_addr;
        sel_wdata = grant_m1 ? m1_wdata : m0_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            lat_cnt      <= '0;
            lat_we       <= 1'b0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            m0_rdata     <= '0;
            m1_rdata     <= '0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            ram_read_en  <= 1'b0;
            ram_write_en <= 1'b0;
            busy         <= 1'b0;
            owner        <= OWNER_RST;
        end else begin
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            ram_read_en  <= 1'b0;
            ram_write_en <= 1'b0;
            case (state)
                // The strobes are loaded here so they are visible during the ACCESS cycle itself.
                IDLE: begin
                    if (m0_req || m1_req) begin
                        owner        <= grant_m1;
                        lat_we       <= sel_we;
                        ram_addr     <= sel_addr;
                        ram_wdata    <= sel_wdata;
                        ram_write_en <= sel_we;
                        ram_read_en  <= !sel_we;
                        busy         <= 1'b1;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (lat_we) begin
                        m0_ack <= !owner;
                        m1_ack <= owner;
                        state  <= DONE;
                    end else begin
                        lat_cnt <= CNT_W'(READ_LATENCY - 1);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        if (owner) begin
                            m1_rdata <= ram_rdata;
                        end else begin
                            m0_rdata <= ram_rdata;
                        end
                        m0_ack <= !owner;
                        m1_ack <= owner;
                        state  <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a READ_LATENCY=1 instance driven from a vector table and
// hand sequences, plus a READ_LATENCY=3 instance for the long-latency read.
module tb_ram_arbiter;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    localparam logic OWNER_RST = 1'b1;
    localparam bit   RR_EN     = 1'b1;
`else
    localparam logic OWNER_RST = 1'b0;
    localparam bit   RR_EN     = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m1_ack, ram_read_en, ram_write_en, busy, owner;
    logic [15:0] m0_rdata, m1_rdata, ram_addr, ram_wdata, ram_rdata;

    logic        d3_m0_req, d3_m0_we, d3_m1_req, d3_m1_we;
    logic [15:0] d3_m0_addr, d3_m0_wdata, d3_m1_addr, d3_m1_wdata;
    logic        d3_m0_ack, d3_m1_ack, d3_ram_read_en, d3_ram_write_en, d3_busy, d3_owner;
    logic [15:0] d3_m0_rdata, d3_m1_rdata, d3_ram_addr, d3_ram_wdata;
    logic [15:0] d3_pipe [0:2];

    logic [15:0] mem [0:65535];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_read_en(ram_read_en),
        .ram_write_en(ram_write_en), .ram_rdata(ram_rdata), .busy(busy), .owner(owner)
    );

    ram_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .m0_req(d3_m0_req), .m0_we(d3_m0_we), .m0_addr(d3_m0_addr), .m0_wdata(d3_m0_wdata),
        .m0_ack(d3_m0_ack), .m0_rdata(d3_m0_rdata),
        .m1_req(d3_m1_req), .m1_we(d3_m1_we), .m1_addr(d3_m1_addr), .m1_wdata(d3_m1_wdata),
        .m1_ack(d3_m1_ack), .m1_rdata(d3_m1_rdata),
        .ram_addr(d3_ram_addr), .ram_wdata(d3_ram_wdata), .ram_read_en(d3_ram_read_en),
        .ram_write_en(d3_ram_write_en), .ram_rdata(d3_pipe[2]), .busy(d3_busy), .owner(d3_owner)
    );

    // RAM models: data appears READ_LATENCY cycles after the strobe, 0xDEAD otherwise.
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_addr] <= ram_wdata;
        ram_rdata  <= ram_read_en ? mem[ram_addr] : 16'hDEAD;
        d3_pipe[0] <= d3_ram_read_en ? ((d3_ram_addr == 16'h2000) ? 16'h1234 : 16'h0BAD) : 16'hDEAD;
        d3_pipe[1] <= d3_pipe[0];
        d3_pipe[2] <= d3_pipe[1];
    end

    typedef struct {
        logic        rst;
        logic        m0_req, m0_we;
        logic [15:0] m0_addr, m0_wdata;
        logic        m1_req, m1_we;
        logic [15:0] m1_addr, m1_wdata;
        logic        e_m0_ack, e_m1_ack;
        logic [15:0] e_m0_rdata, e_m1_rdata, e_ram_addr, e_ram_wdata;
        logic        e_rd, e_wr, e_busy, e_owner;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst      = v.rst;
        m0_req   = v.m0_req;
        m0_we    = v.m0_we;
        m0_addr  = v.m0_addr;
        m0_wdata = v.m0_wdata;
        m1_req   = v.m1_req;
        m1_we    = v.m1_we;
        m1_addr  = v.m1_addr;
        m1_wdata = v.m1_wdata;
    endtask

    initial begin
        int grants;
        int cyc;
        logic exp_m1;

        d3_m0_req = 0; d3_m0_we = 0; d3_m0_addr = 0; d3_m0_wdata = 0;
        d3_m1_req = 0; d3_m1_we = 0; d3_m1_addr = 0; d3_m1_wdata = 0;

        //             rst m0:req we addr      wdata     m1:req we addr      wdata     ack0 ack1 rdata0    rdata1 ram_addr  ram_wdata rd wr busy owner
        vecs[0]  = '{1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0, 16'h0000, 16'h0000, 0, 0, 0, OWNER_RST};
        vecs[1]  = '{0, 1, 1, 16'h0100, 16'hBEEF, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0, 16'h0100, 16'hBEEF, 0, 1, 1, 0};
        vecs[2]  = '{0, 1, 1, 16'h0100, 16'hBEEF, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0, 16'h0100, 16'hBEEF, 0, 0, 1, 0};
        vecs[3]  = '{0, 1, 1, 16'h0100, 16'hBEEF, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0, 16'h0100, 16'hBEEF, 0, 0, 0, 0};
        vecs[4]  = '{0, 1, 0, 16'h0100, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0, 16'h0100, 16'h0000, 1, 0, 1, 0};
        vecs[5]  = '{0, 1, 0, 16'h0100, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0, 16'h0100, 16'h0000, 0, 0, 1, 0};
        vecs[6]  = '{0, 1, 0, 16'h0100, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'hBEEF, 16'h0, 16'h0100, 16'h0000, 0, 0, 1, 0};
        vecs[7]  = '{0, 1, 0, 16'h0100, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'hBEEF, 16'h0, 16'h0100, 16'h0000, 0, 0, 0, 0};
        vecs[8]  = '{0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h3000, 16'h5555, 0, 0, 16'hBEEF, 16'h0, 16'h3000, 16'h5555, 0, 1, 1, 1};
        vecs[9]  = '{0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h3000, 16'h5555, 0, 1, 16'hBEEF, 16'h0, 16'h3000, 16'h5555, 0, 0, 1, 1};
        vecs[10] = '{0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h3000, 16'h5555, 0, 0, 16'hBEEF, 16'h0, 16'h3000, 16'h5555, 0, 0, 0, 1};
        vecs[11] = '{0, 1, 0, 16'h3000, 16'h0000, 1, 1, 16'h3000, 16'h5555, 0, 0, 16'hBEEF, 16'h0, 16'h3000, 16'h0000, 1, 0, 1, 0};
        vecs[12] = '{0, 1, 0, 16'h3000, 16'h0000, 1, 1, 16'h3000, 16'h5555, 0, 0, 16'hBEEF, 16'h0, 16'h3000, 16'h0000, 0, 0, 1, 0};
        vecs[13] = '{0, 1, 0, 16'h3000, 16'h0000, 1, 1, 16'h3000, 16'h5555, 1, 0, 16'h5555, 16'h0, 16'h3000, 16'h0000, 0, 0, 1, 0};
        vecs[14] = '{0, 1, 0, 16'h3000, 16'h0000, 1, 1, 16'h3000, 16'h5555, 0, 0, 16'h5555, 16'h0, 16'h3000, 16'h0000, 0, 0, 0, 0};
        vecs[15] = '{0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h3000, 16'h5555, 0, 0, 16'h5555, 16'h0, 16'h3000, 16'h5555, 0, 1, 1, 1};
        vecs[16] = '{0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h3000, 16'h5555, 0, 1, 16'h5555, 16'h0, 16'h3000, 16'h5555, 0, 0, 1, 1};
        vecs[17] = '{0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h5555, 16'h0, 16'h3000, 16'h5555, 0, 0, 0, 1};

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("v%0d_m0_ack", i), 32'(m0_ack), 32'(vecs[i].e_m0_ack));
            checkOutput($sformatf("v%0d_m1_ack", i), 32'(m1_ack), 32'(vecs[i].e_m1_ack));
            checkOutput($sformatf("v%0d_m0_rdata", i), 32'(m0_rdata), 32'(vecs[i].e_m0_rdata));
            checkOutput($sformatf("v%0d_m1_rdata", i), 32'(m1_rdata), 32'(vecs[i].e_m1_rdata));
            checkOutput($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(vecs[i].e_ram_addr));
            checkOutput($sformatf("v%0d_ram_wdata", i), 32'(ram_wdata), 32'(vecs[i].e_ram_wdata));
            checkOutput($sformatf("v%0d_read_en", i), 32'(ram_read_en), 32'(vecs[i].e_rd));
            checkOutput($sformatf("v%0d_write_en", i), 32'(ram_write_en), 32'(vecs[i].e_wr));
            checkOutput($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            checkOutput($sformatf("v%0d_owner", i), 32'(owner), 32'(vecs[i].e_owner));
        end

        // Continuous contention: ten grants, each checked against the arbitration policy.
        m0_req = 1; m0_we = 1; m0_addr = 16'h0010; m0_wdata = 16'h1111;
        m1_req = 1; m1_we = 1; m1_addr = 16'h0020; m1_wdata = 16'h2222;
        grants = 0;
        cyc = 0;
        while (grants < 10 && cyc < 40) begin
            tick();
            cyc++;
            if (m0_ack || m1_ack) begin
                exp_m1 = RR_EN ? logic'(grants % 2) : 1'b0;
                checkOutput($sformatf("tie_grant%0d_m1", grants), 32'(m1_ack), 32'(exp_m1));
                checkOutput($sformatf("tie_grant%0d_m0", grants), 32'(m0_ack), 32'(!exp_m1));
                grants++;
            end
        end
        checkOutput("tie_grant_count", 32'(grants), 32'd10);
        m0_req = 0; m1_req = 0;
        tick();
        tick();
        checkOutput("tie_drain_busy", 32'(busy), 32'd0);

        // Reset while an m1 read sits in WAIT.
        m1_req = 1; m1_we = 0; m1_addr = 16'h3000; m1_wdata = 16'h0000;
        tick();
        checkOutput("rst_seq_read_en", 32'(ram_read_en), 32'd1);
        tick();
        checkOutput("rst_seq_wait_busy", 32'(busy), 32'd1);
        rst = 1;
        tick();
        rst = 0; m1_req = 0;
        checkOutput("rst_seq_m1_ack", 32'(m1_ack), 32'd0);
        checkOutput("rst_seq_m1_rdata", 32'(m1_rdata), 32'd0);
        checkOutput("rst_seq_m0_rdata", 32'(m0_rdata), 32'd0);
        checkOutput("rst_seq_ram_addr", 32'(ram_addr), 32'd0);
        checkOutput("rst_seq_enables", 32'({ram_read_en, ram_write_en}), 32'd0);
        checkOutput("rst_seq_busy", 32'(busy), 32'd0);
        checkOutput("rst_seq_owner", 32'(owner), 32'(OWNER_RST));
        tick();
        checkOutput("rst_seq_no_late_ack", 32'(m1_ack), 32'd0);

        // m0 write after reset; address changes during ACCESS must not leak through.
        m0_req = 1; m0_we = 1; m0_addr = 16'h0100; m0_wdata = 16'hCAFE;
        tick();
        checkOutput("chg_write_en", 32'(ram_write_en), 32'd1);
        checkOutput("chg_ram_addr", 32'(ram_addr), 32'h0100);
        checkOutput("chg_ram_wdata", 32'(ram_wdata), 32'hCAFE);
        m0_addr = 16'h0FFF;
        tick();
        checkOutput("chg_m0_ack", 32'(m0_ack), 32'd1);
        checkOutput("chg_ram_addr_done", 32'(ram_addr), 32'h0100);
        tick();
        checkOutput("chg_no_second_access", 32'({ram_read_en, ram_write_en, busy}), 32'd0);
        checkOutput("chg_ack_single", 32'(m0_ack), 32'd0);
        m0_req = 0;
        tick();
        checkOutput("chg_mem_0100", 32'(mem[16'h0100]), 32'hCAFE);
        checkOutput("chg_mem_0fff", 32'(mem[16'h0FFF]) == 32'hCAFE ? 32'd1 : 32'd0, 32'd0);

        // READ_LATENCY=3: m1 read of 0x2000, ack five cycles after the request.
        d3_m1_req = 1; d3_m1_we = 0; d3_m1_addr = 16'h2000;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checkOutput($sformatf("rl3_busy_c%0d", k), 32'(d3_busy), (k <= 5) ? 32'd1 : 32'd0);
            checkOutput($sformatf("rl3_m1_ack_c%0d", k), 32'(d3_m1_ack), (k == 5) ? 32'd1 : 32'd0);
            if (k == 5) begin
                checkOutput("rl3_m1_rdata", 32'(d3_m1_rdata), 32'h1234);
                d3_m1_req = 0;
            end
        end
        checkOutput("rl3_m0_rdata", 32'(d3_m0_rdata), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
